pipelined_approx_adder: RTL
===========================

# pipelined_approx_adder

Two-stage pipelined N-bit adder with a selectable exact or lower-part-OR approximate mode, a valid/ready handshake on both sides, and an error-statistics unit. In approximate mode the low K bits are OR-combined and the carry into the exact upper part is `a[K-1] & b[K-1]`. The block replaces the purely combinational ripple-carry adder wherever adders are streamed from a data source and approximation error must be measured in hardware.

## Interface
Parameters:
- `N`, default 8, operand width (≥2).
- `K`, default 4, number of approximated LSBs (0..N).
- `ERRW`, default 16, width of the error counter.

Ports:
- `clk`, input, 1, rising-edge clock.
- `rst`, input, 1, asynchronous, active-high reset.
- `in_valid`, input, 1, operand pair present.
- `in_ready`, output, 1, block accepts operands this cycle.
- `a`, input, N, operand A (unsigned).
- `b`, input, N, operand B (unsigned).
- `mode`, input, 1, 0 = exact, 1 = approximate; sampled with operands.
- `out_valid`, output, 1, result present.
- `out_ready`, input, 1, downstream accepts result.
- `total`, output, N+1, sum including carry-out.
- `err_dist`, output, N+1, |exact − total| for the current output.
- `err_count`, output, ERRW, count of accepted approximate results with non-zero error.
- `err_clear`, input, 1, synchronous clear of `err_count`.

## Operation
- **Transfer rules.**
  - An input is accepted on an edge where `in_valid & in_ready`.
  - An output is consumed on an edge where `out_valid & out_ready`.
- **Stage 1 (lower part).** Registers:
  - lower result: the exact K-bit sum, or `a[K-1:0] | b[K-1:0]` when `mode`=1;
  - carry into the upper part: the real lower carry, or `a[K-1]&b[K-1]` when approximate;
  - `a[N-1:K]`, `b[N-1:K]`, `mode`, and the exact lower carry for error computation.
- **Stage 2 (upper part).**
  - Computes `a_hi + b_hi + carry` as N−K+1 bits.
  - `total = {upper, lower}`.
  - Also registers the exact full sum for the error unit.
- **K = 0.** Approximate mode is identical to exact mode.
- **K = N.**
  - `total[N-1:0] = a|b` and `total[N] = a[N-1]&b[N-1]`.
  - No upper adder is instantiated.
- **Stall control.**
  - `s2_adv = !s2_valid | out_ready`.
  - `s1_adv = !s1_valid | s2_adv`.
  - `in_ready = s1_adv`. This is a combinational path from `out_ready` to `in_ready` and is allowed.
  - A stalled stage holds its data unchanged.
  - Results leave in acceptance order; none are dropped or duplicated.
- **Error unit.**
  - `err_dist = exact_sum − total` (the approximation never exceeds exact? no — compute the absolute difference).
  - `err_dist` is 0 whenever `mode`=0.
  - `err_count` increments on a consumed output with `mode`=1 and `err_dist`≠0.
  - `err_count` saturates at 2^ERRW−1.
  - `err_clear` wins over a simultaneous increment: the count becomes 0.
- **Reset.**
  - Values after reset: `out_valid`=0, `in_ready`=1, `total`=0, `err_dist`=0, `err_count`=0.
  - A reset mid-stream discards all in-flight data.

## Timing
- **Latency.** Operands accepted on edge t appear with `out_valid`=1 after edge t+1 (2 register stages), given `out_ready` has not stalled.
- **Throughput.** One result per cycle while `out_ready`=1.
- **Backpressure.**
  - With `out_ready`=0, the pipeline absorbs at most 2 transfers.
  - `in_ready` falls in the same cycle in which both stages are full and `out_ready`=0.
- **Output stability.** `total` and `err_dist` remain stable while `out_valid & !out_ready`.
- **Counter timing.** `err_count` updates on the consuming edge and is visible in the following cycle.

## Configuration
- `APPROX_ERR_STATS_EN`
  - Defined: the exact reference path, `err_dist`, and `err_count` are implemented as described above.
  - Undefined: the exact reference path is removed. `err_dist` is tied to 0, `err_count` to 0, and `err_clear` is ignored. The datapath and handshake are unchanged.

## Test plan
All scenarios use N=8, K=4 with the macro defined unless stated otherwise.
1. **Exact mode.** `mode`=0, a=0x30, b=0x05 → `total`=0x035 two cycles later, `err_dist`=0, `err_count` stays 0.
2. **Approximate, single-bit error.** `mode`=1, a=0x0F, b=0x01 → `total`=0x00F, `err_dist`=1, `err_count`=1 after consumption.
3. **Approximate, carry over-estimate.** `mode`=1, a=0x08, b=0x08 → `total`=0x018 (exact 0x010), `err_dist`=8. Also a=0x47, b=0x70 → `total`=0x0B7, `err_dist`=0, count unchanged.
4. **Backpressure.** Stream 4 exact pairs back-to-back with `out_ready`=0 for the first 4 cycles:
   - `in_ready` drops after 2 acceptances;
   - after release, all 4 sums emerge in order, with no loss and no duplicates.
5. **Saturation and clear.** With ERRW=2, consume 5 erroneous approximate results → `err_count`=3. Then assert `err_clear` together with a sixth erroneous consume → `err_count`=0.
6. **Reset mid-stream.** Assert `rst` with both stages full → `out_valid`=0 and `err_count`=0 immediately; the first new input after reset yields a correct result 2 cycles later. Separately, build with the macro undefined → `err_dist`/`err_count` stay 0 under the inputs of scenario 2.

Source files
------------

// File: rtl/pipelined_approx_adder.sv
// pipelined_approx_adder
//   Two-stage pipelined N-bit unsigned adder with exact or lower-part-OR
//   approximate mode, valid/ready handshake on both sides and optional
//   hardware error statistics.
//
//   Optional feature macro: APPROX_ERR_STATS_EN
//     defined   : exact reference path, err_dist and err_count implemented
//     undefined : err_dist and err_count tied to 0, err_clear ignored
//
// Parameters
//   N    operand width (>= 2)
//   K    number of approximated LSBs (0..N)
//   ERRW width of the saturating error counter
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand pair present          in_ready  operands accepted this cycle
//   a, b       unsigned operands             mode      0 = exact, 1 = approximate
//   out_valid  result present                out_ready downstream accepts result
//   total      N+1 bit sum incl. carry-out
//   err_dist   |exact - total| of the current output
//   err_count  saturating count of consumed approximate results with error
//   err_clear  synchronous clear of err_count (wins over an increment)
module pipelined_approx_adder #(
    parameter int N    = 8,
    parameter int K    = 4,
    parameter int ERRW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    a,
    input  logic [N-1:0]    b,
    input  logic            mode,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N:0]      total,
    output logic [N:0]      err_dist,
    output logic [ERRW-1:0] err_count,
    input  logic            err_clear
);

    // Bit masks selecting the approximated low part, the exact upper part,
    // and the top bit of the low part (which feeds the approximate carry).
    // K = 0 makes LO_MASK and LO_TOP zero, so approximate equals exact.
    localparam logic [N-1:0] LO_MASK = {N{1'b1}} >> (N - K);
    localparam logic [N-1:0] HI_MASK = ~LO_MASK;
    localparam logic [N-1:0] LO_TOP  = LO_MASK ^ (LO_MASK >> 1);

    // ---------------- handshake ----------------
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s1_adv, s2_adv;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    // ---------------- stage 1: lower part ----------------
    logic [N:0]   lo_sum;      // exact low-part sum; its carry lands on bit K
    logic [N-1:0] lo_or;
    logic         lo_carry;
    logic         approx_cin;

    assign lo_sum     = {1'b0, a & LO_MASK} + {1'b0, b & LO_MASK};
    assign lo_carry   = lo_sum[K];
    assign approx_cin = |(a & b & LO_TOP);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lo_or
            if (gi < K) begin : g_approx
                assign lo_or[gi] = a[gi] | b[gi];
            end else begin : g_exact
                assign lo_or[gi] = 1'b0;
            end
        end
    endgenerate

    // Upper operands are kept in place (low K bits zero) so the upper sum
    // can be OR-merged with the lower result without any re-alignment.
    logic [N-1:0] s1_a_hi_q, s1_a_hi_d;
    logic [N-1:0] s1_b_hi_q, s1_b_hi_d;
    logic [N-1:0] s1_lo_q,   s1_lo_d;
    logic         s1_cin_q,  s1_cin_d;

    // ---------------- stage 2: upper part ----------------
    logic [N:0] hi_sum;
    logic [N:0] s2_total_q, s2_total_d;

    assign hi_sum     = {1'b0, s1_a_hi_q} + {1'b0, s1_b_hi_q};
    assign s2_total_d = (hi_sum + ((N+1)'(s1_cin_q) << K)) | {1'b0, s1_lo_q};

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_hi_d  = s1_a_hi_q;
        s1_b_hi_d  = s1_b_hi_q;
        s1_lo_d    = s1_lo_q;
        s1_cin_d   = s1_cin_q;
        s2_valid_d = s2_valid_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_a_hi_d = a & HI_MASK;
                s1_b_hi_d = b & HI_MASK;
                s1_lo_d   = mode ? lo_or : (lo_sum[N-1:0] & LO_MASK);
                s1_cin_d  = mode ? approx_cin : lo_carry;
            end
        end
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_hi_q  <= '0;
            s1_b_hi_q  <= '0;
            s1_lo_q    <= '0;
            s1_cin_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_total_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_hi_q  <= s1_a_hi_d;
            s1_b_hi_q  <= s1_b_hi_d;
            s1_lo_q    <= s1_lo_d;
            s1_cin_q   <= s1_cin_d;
            s2_valid_q <= s2_valid_d;
            // Only load when a valid item moves in, so a drained stage keeps
            // its last result and a stalled one holds still.
            if (s2_adv && s1_valid_q) begin
                s2_total_q <= s2_total_d;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign total     = s2_total_q;

    // ---------------- error statistics ----------------
`ifdef APPROX_ERR_STATS_EN
    logic [N-1:0]    s1_exact_lo_q, s1_exact_lo_d;
    logic            s1_exact_c_q,  s1_exact_c_d;
    logic            s1_mode_q,     s1_mode_d;
    logic [N:0]      s2_exact_q,    s2_exact_d;
    logic            s2_mode_q;
    logic [ERRW-1:0] err_count_q,   err_count_d;
    logic            consume;

    assign consume    = s2_valid_q && out_ready;
    assign s2_exact_d = (hi_sum + ((N+1)'(s1_exact_c_q) << K)) | {1'b0, s1_exact_lo_q};

    // The approximate total may fall either side of the exact sum.
    assign err_dist = (s2_exact_q >= s2_total_q) ? (s2_exact_q - s2_total_q)
                                                 : (s2_total_q - s2_exact_q);

    always_comb begin
        s1_exact_lo_d = s1_exact_lo_q;
        s1_exact_c_d  = s1_exact_c_q;
        s1_mode_d     = s1_mode_q;
        if (s1_adv && in_valid) begin
            s1_exact_lo_d = lo_sum[N-1:0] & LO_MASK;
            s1_exact_c_d  = lo_carry;
            s1_mode_d     = mode;
        end
        err_count_d = err_count_q;
        if (err_clear) begin
            err_count_d = '0;
        end else if (consume && s2_mode_q && (err_dist != '0) && (err_count_q != '1)) begin
            err_count_d = err_count_q + ERRW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_exact_lo_q <= '0;
            s1_exact_c_q  <= 1'b0;
            s1_mode_q     <= 1'b0;
            s2_exact_q    <= '0;
            s2_mode_q     <= 1'b0;
            err_count_q   <= '0;
        end else begin
            s1_exact_lo_q <= s1_exact_lo_d;
            s1_exact_c_q  <= s1_exact_c_d;
            s1_mode_q     <= s1_mode_d;
            if (s2_adv && s1_valid_q) begin
                s2_exact_q <= s2_exact_d;
                s2_mode_q  <= s1_mode_q;
            end
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`else
    logic unused_err_clear;

    assign unused_err_clear = err_clear;
    assign err_dist         = '0;
    assign err_count        = '0;
`endif

endmodule
